// File: rtl/axi_stream_insert_header_v2.sv
// AXI-Stream header inserter: prepends 0..N header bytes to each packet and
// repacks the payload byte-contiguously, adding a tail-flush beat on overflow.
module axi_stream_insert_header_v2 #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      header_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD:0]    byte_insert_cnt,
  output logic                    ready_insert,
  output logic                    err_hdr
);

  localparam int unsigned N  = DATA_BYTE_WD;
  localparam int unsigned CW = BYTE_CNT_WD + 1;
  localparam int unsigned SW = BYTE_CNT_WD + 2;

  typedef logic [N-1:0]       keep_t;
  typedef logic [DATA_WD-1:0] data_t;
  typedef logic [CW-1:0]      cnt_t;
  typedef logic [SW-1:0]      sum_t;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  function automatic keep_t top_ones(input sum_t n);
    keep_t m;
    m = '0;
    for (int unsigned i = 0; i < N; i++)
      if (i < 32'(n)) m[N-1-i] = 1'b1;
    return m;
  endfunction

  function automatic keep_t low_ones(input cnt_t n);
    keep_t m;
    m = '0;
    for (int unsigned i = 0; i < N; i++)
      if (i < 32'(n)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic data_t byte_mask(input keep_t k);
    data_t m;
    m = '0;
    for (int unsigned i = 0; i < N; i++)
      m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic sum_t lead_ones(input keep_t k);
    sum_t c;
    logic run;
    c   = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (run && k[N-1-i]) c = c + sum_t'(1);
      else                 run = 1'b0;
    end
    return c;
  endfunction

  // Top beat of {hi, lo} after dropping the N-h unused upper bytes of hi:
  // hi's low h bytes lead, followed by lo's top N-h bytes.
  function automatic data_t repack(input data_t hi, input data_t lo, input cnt_t h);
    logic [2*DATA_WD-1:0] cat;
    cat = {hi, lo} << (8 * (N - 32'(h)));
    return cat[2*DATA_WD-1 -: DATA_WD];
  endfunction

  state_t state_q, state_d;
  cnt_t   h_q, h_d;
  data_t  res_q, res_d;
  keep_t  fkeep_q, fkeep_d;
  logic   floaded_q, floaded_d;
  logic   vout_q, vout_d;
  data_t  dout_q, dout_d;
  keep_t  kout_q, kout_d;
  logic   lout_q, lout_d;
  logic   err_q, err_d;

  logic   upd, in_acc, hdr_acc, cnt_ovf;
  cnt_t   hdr_cnt;
  sum_t   k_cnt, hk_sum;
  keep_t  beat_keep;

  assign upd          = !vout_q || ready_out;
  assign ready_insert = (state_q == IDLE);
  assign ready_in     = (state_q == STREAM) && upd;
  assign in_acc       = valid_in && ready_in;
  assign hdr_acc      = valid_insert && ready_insert;
  assign cnt_ovf      = (32'(byte_insert_cnt) > N);
  assign hdr_cnt      = cnt_ovf ? cnt_t'(N) : byte_insert_cnt;
  assign k_cnt        = lead_ones(keep_in);
  assign hk_sum       = sum_t'(h_q) + k_cnt;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    res_d     = res_q;
    fkeep_d   = fkeep_q;
    floaded_d = floaded_q;
    vout_d    = vout_q;
    dout_d    = dout_q;
    kout_d    = kout_q;
    lout_d    = lout_q;
    err_d     = err_q;
    beat_keep = '1;
    case (state_q)
      IDLE: begin
        if (upd) vout_d = 1'b0;
        if (hdr_acc) begin
          h_d     = hdr_cnt;
          res_d   = header_insert & byte_mask(low_ones(hdr_cnt));
          state_d = STREAM;
          if (cnt_ovf || (keep_insert != low_ones(hdr_cnt))) err_d = 1'b1;
        end
      end
      STREAM: begin
        if (upd) vout_d = 1'b0;
        if (in_acc) begin
          if (last_in ? (keep_in != top_ones(k_cnt)) : (keep_in != '1)) err_d = 1'b1;
          lout_d = last_in;
          if (last_in) state_d = IDLE;
          if (h_q == '0) begin
            beat_keep = keep_in;
          end else if (last_in) begin
            if (hk_sum <= sum_t'(N)) begin
              beat_keep = top_ones(hk_sum);
            end else begin
              lout_d    = 1'b0;
              fkeep_d   = top_ones(hk_sum - sum_t'(N));
              floaded_d = 1'b0;
              state_d   = FLUSH;
            end
          end
          vout_d = 1'b1;
          kout_d = beat_keep;
          dout_d = repack(res_q, data_in, h_q) & byte_mask(beat_keep);
          res_d  = data_in & byte_mask(low_ones(h_q));
        end
      end
      FLUSH: begin
        // First opening loads the tail beat; the next one means it was taken.
        if (upd) begin
          if (!floaded_q) begin
            vout_d    = 1'b1;
            floaded_d = 1'b1;
            kout_d    = fkeep_q;
            lout_d    = 1'b1;
            dout_d    = repack(res_q, '0, h_q) & byte_mask(fkeep_q);
          end else begin
            vout_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      h_q       <= '0;
      res_q     <= '0;
      fkeep_q   <= '0;
      floaded_q <= 1'b0;
      vout_q    <= 1'b0;
      dout_q    <= '0;
      kout_q    <= '0;
      lout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      res_q     <= res_d;
      fkeep_q   <= fkeep_d;
      floaded_q <= floaded_d;
      vout_q    <= vout_d;
      dout_q    <= dout_d;
      kout_q    <= kout_d;
      lout_q    <= lout_d;
      err_q     <= err_d;
    end
  end

  assign valid_out = vout_q;
  assign data_out  = dout_q;
  assign keep_out  = kout_q;
  assign last_out  = lout_q;
  assign err_hdr   = err_q;

endmodule

// File: tb/tb_axi_stream_insert_header_v2.sv
// Bench for axi_stream_insert_header_v2: byte-queue packet model, per-cycle
// output compare, and directed packets with literal expectations.
module tb_axi_stream_insert_header_v2;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_insert = 1'b0;
  logic [31:0] header_insert = '0;
  logic [3:0]  keep_insert = '0;
  logic [2:0]  byte_insert_cnt = '0;
  logic        ready_insert;
  logic        err_hdr;

  axi_stream_insert_header_v2 #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .header_insert(header_insert),
    .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt),
    .ready_insert(ready_insert), .err_hdr(err_hdr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t expq[$];
  beat_t got[$];
  bit    exp_err = 1'b0;
  int    np;
  logic [31:0] pd[8];
  logic [3:0]  pk[8];
  int    waits;
  int    rmode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Packet as a flat byte sequence, re-chunked into left-aligned beats.
  function automatic void model_packet(input logic [31:0] hdr, input int cnt, input logic [3:0] kins);
    logic [7:0] bq[$];
    int         h;
    logic [3:0] lowm;
    beat_t      t;
    h    = (cnt > N) ? N : cnt;
    lowm = '0;
    for (int i = 0; i < h; i++) lowm[i] = 1'b1;
    if (cnt > N || kins != lowm) exp_err = 1'b1;
    for (int i = h - 1; i >= 0; i--) bq.push_back(hdr[i*8 +: 8]);
    for (int b = 0; b < np; b++) begin
      int         k;
      bit         run;
      logic [3:0] want;
      k = 0; run = 1'b1; want = '0;
      for (int i = N - 1; i >= 0; i--)
        if (run && pk[b][i]) k++; else run = 1'b0;
      for (int i = 0; i < k; i++) want[N-1-i] = 1'b1;
      if ((b == np - 1) ? (pk[b] != want) : (pk[b] != 4'hF)) exp_err = 1'b1;
      for (int i = 0; i < k; i++) bq.push_back(pd[b][(N-1-i)*8 +: 8]);
    end
    do begin
      t.d = '0; t.k = '0;
      for (int i = 0; i < N; i++)
        if (bq.size() > 0) begin
          t.d[(N-1-i)*8 +: 8] = bq.pop_front();
          t.k[N-1-i] = 1'b1;
        end
      t.l = (bq.size() == 0);
      expq.push_back(t);
    end while (bq.size() > 0);
  endfunction

  bit prev_stall = 1'b0;
  logic [36:0] prev_v;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_stable", {valid_out, last_out, keep_out, data_out}, {1'b1, prev_v});
      if (valid_out && !ready_out) chk("ready_in_stall", ready_in, 1'b0);
      if (valid_out && ready_out) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=%0h/%0h/%0h required=none", data_out, keep_out, last_out);
        end else begin
          e = expq.pop_front();
          chk("beat", {last_out, keep_out, data_out}, {e.l, e.k, e.d});
        end
        e.d = data_out; e.k = keep_out; e.l = last_out;
        got.push_back(e);
      end
      prev_stall = valid_out && !ready_out;
      prev_v     = {last_out, keep_out, data_out};
    end
  end

  initial begin
    bit pat[6];
    int pi;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pi = 0;
    ready_out = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rmode == 1) begin ready_out = pat[pi]; pi = (pi + 1) % 6; end
      else if (rmode == 0) ready_out = 1'b1;
      else ready_out = 1'b0;
    end
  end

  task automatic send_hdr(input logic [31:0] hdr, input int cnt, input logic [3:0] kins);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    valid_insert = 1'b1; header_insert = hdr; byte_insert_cnt = 3'(cnt); keep_insert = kins;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ready_insert) begin ok = 1'b1; break; end
    end
    chk("hdr_handshake", ok, 1'b1);
    @(posedge clk); #1;
    valid_insert = 1'b0;
    chk("err_after_hdr", err_hdr, exp_err);
  endtask

  task automatic send_payload();
    bit ok;
    waits = 0;
    for (int b = 0; b < np; b++) begin
      valid_in = 1'b1; data_in = pd[b]; keep_in = pk[b]; last_in = (b == np - 1);
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        waits++;
        chk("ready_in_rule", ready_in, !valid_out || ready_out);
        if (ready_in) begin ok = 1'b1; break; end
      end
      chk("beat_handshake", ok, 1'b1);
      @(posedge clk); #1;
      chk("latency", valid_out, 1'b1);
    end
    valid_in = 1'b0; last_in = 1'b0;
    chk("err_after_pkt", err_hdr, exp_err);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && expq.size() > 0; t++) @(negedge clk);
    chk("drain", 64'(expq.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [31:0] hdr, input int cnt, input logic [3:0] kins);
    got.delete();
    model_packet(hdr, cnt, kins);
    send_hdr(hdr, cnt, kins);
    send_payload();
    drain();
  endtask

  task automatic check_got(input string name, input int idx, input logic [31:0] d,
                           input logic [3:0] k, input logic l);
    if (got.size() <= idx) begin
      checks++; errors++;
      $display("FAIL %s actual=missing required=%0h/%0h/%0h", name, d, k, l);
    end else begin
      chk(name, {got[idx].l, got[idx].k, got[idx].d}, {l, k, d});
    end
  endtask

  task automatic case1_payload();
    np = 2; pd[0] = 32'h11223344; pk[0] = 4'hF; pd[1] = 32'h55667788; pk[1] = 4'hC;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_last_out", last_out, 1'b0);
    chk("rst_data_keep", {keep_out, data_out}, 36'd0);
    chk("rst_err", err_hdr, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready_insert", ready_insert, 1'b1);
    chk("idle_ready_in", ready_in, 1'b0);

    // 1: two-byte header, no overflow
    case1_payload();
    run(32'h0000AABB, 2, 4'h3);
    check_got("t1_b0", 0, 32'hAABB1122, 4'hF, 1'b0);
    check_got("t1_b1", 1, 32'h33445566, 4'hF, 1'b1);
    chk("t1_count", 64'(got.size()), 64'd2);
    chk("t1_err", err_hdr, 1'b0);

    // 2: three-byte header overflows into a flush beat
    got.delete();
    np = 1; pd[0] = 32'h11223344; pk[0] = 4'hE;
    model_packet(32'h00CCDDEE, 3, 4'h7);
    send_hdr(32'h00CCDDEE, 3, 4'h7);
    send_payload();
    @(negedge clk);
    chk("t2_flush_ready_in", ready_in, 1'b0);
    chk("t2_flush_ready_insert", ready_insert, 1'b0);
    drain();
    check_got("t2_b0", 0, 32'hCCDDEE11, 4'hF, 1'b0);
    check_got("t2_b1", 1, 32'h22330000, 4'hC, 1'b1);

    // 3: zero-byte header bypass at full rate
    np = 2; pd[0] = 32'hDEADBEEF; pk[0] = 4'hF; pd[1] = 32'h01020304; pk[1] = 4'h8;
    run(32'h12345678, 0, 4'h0);
    chk("t3_throughput", 64'(waits), 64'd2);
    check_got("t3_b0", 0, 32'hDEADBEEF, 4'hF, 1'b0);
    check_got("t3_b1", 1, 32'h01000000, 4'h8, 1'b1);

    // 3b: full-width header, single full payload beat
    np = 1; pd[0] = 32'h11223344; pk[0] = 4'hF;
    run(32'hA1A2A3A4, 4, 4'hF);
    check_got("t3b_b0", 0, 32'hA1A2A3A4, 4'hF, 1'b0);
    check_got("t3b_b1", 1, 32'h11223344, 4'hF, 1'b1);

    // 4: case 1 under sink back-pressure
    rmode = 1;
    case1_payload();
    run(32'h0000AABB, 2, 4'h3);
    rmode = 0;
    repeat (2) @(negedge clk);
    check_got("t4_b0", 0, 32'hAABB1122, 4'hF, 1'b0);
    check_got("t4_b1", 1, 32'h33445566, 4'hF, 1'b1);
    chk("t4_count", 64'(got.size()), 64'd2);

    // 5: reset while the flush beat is pending
    rmode = 2;
    got.delete();
    np = 1; pd[0] = 32'h11223344; pk[0] = 4'hE;
    model_packet(32'h00CCDDEE, 3, 4'h7);
    send_hdr(32'h00CCDDEE, 3, 4'h7);
    send_payload();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("t5_async_valid", valid_out, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expq.delete(); got.delete(); exp_err = 1'b0;
    rmode = 0;
    @(negedge clk);
    chk("t5_valid_out", valid_out, 1'b0);
    chk("t5_ready_insert", ready_insert, 1'b1);
    case1_payload();
    run(32'h0000AABB, 2, 4'h3);
    check_got("t5_b0", 0, 32'hAABB1122, 4'hF, 1'b0);
    check_got("t5_b1", 1, 32'h33445566, 4'hF, 1'b1);

    // 6: inconsistent keep_insert sets the sticky error, H still from count
    case1_payload();
    run(32'h0000AABB, 2, 4'h5);
    chk("t6_err", err_hdr, 1'b1);
    check_got("t6_b0", 0, 32'hAABB1122, 4'hF, 1'b0);
    check_got("t6_b1", 1, 32'h33445566, 4'hF, 1'b1);

    // 6b: over-range count saturates to N; error stays set
    np = 1; pd[0] = 32'h11223344; pk[0] = 4'hF;
    run(32'hA1A2A3A4, 5, 4'hF);
    check_got("t6b_b0", 0, 32'hA1A2A3A4, 4'hF, 1'b0);
    check_got("t6b_b1", 1, 32'h11223344, 4'hF, 1'b1);
    repeat (5) @(negedge clk);
    chk("t6b_err_sticky", err_hdr, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
